// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory/writeback stage: funct3 codes, writeback
// select encodings, FSM state encoding and the alignment check helper.
package mem_wb_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// Data-memory request/response bus between the mem_wb stage (master) and the
// data memory (slave).
interface mem_wb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] addr;
    logic [3:0]        we;
    logic [DWIDTH-1:0] din;
    logic              rvalid;
    logic [DWIDTH-1:0] dout;

    modport master (
        output req_valid, addr, we, din,
        input  req_ready, rvalid, dout
    );

    modport slave (
        input  req_valid, addr, we, din,
        output req_ready, rvalid, dout
    );
endinterface

// File: rtl/mem_wb_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load funct3.
module mem_wb_load_align
    import mem_wb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DWIDTH-1:0] word,
    output logic [DWIDTH-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and extension
    always_comb begin
        byte_s = word[{addr_lo, 3'b000} +: 8];
        half_s = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            FNC_LB:  data = {{(DWIDTH-8){byte_s[7]}}, byte_s};
            FNC_LH:  data = {{(DWIDTH-16){half_s[15]}}, half_s};
            FNC_LBU: data = {{(DWIDTH-8){1'b0}}, byte_s};
            FNC_LHU: data = {{(DWIDTH-16){1'b0}}, half_s};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// Memory/writeback stage: issues data-memory requests with lane-aligned store
// data, extends load data, and drives the registered regfile write/forward port.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DWIDTH-1:0] ex_alu_out,
    input  logic [DWIDTH-1:0] ex_rs2_data,
    input  logic [DWIDTH-1:0] ex_csr_data,
    input  logic [DWIDTH-1:0] ex_pc,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [2:0]        ex_funct3,
    input  logic [1:0]        ex_wb_sel,
    mem_wb_if.master          dmem,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DWIDTH-1:0] wb_data,
    output logic              misalign_err
);

    state_e            state_r;
    logic [4:0]        rd_r;
    logic [2:0]        funct3_r;
    logic [1:0]        addr_lo_r;
    logic              is_store_r;

    logic              mem_op_s;
    logic              misalign_s;
    logic [3:0]        st_we_s;
    logic [DWIDTH-1:0] st_din_s;
    logic [DWIDTH-1:0] result_s;
    logic [DWIDTH-1:0] load_data_s;

    assign ex_ready   = (state_r == ST_IDLE);
    assign mem_op_s   = ex_mem_rd | ex_mem_wr;
    assign misalign_s = is_misaligned(ex_funct3[1:0], ex_alu_out[1:0]);

    // Store lane alignment: replicate the datum across lanes, enable only the addressed ones
    always_comb begin
        st_we_s  = 4'b1111;
        st_din_s = ex_rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_we_s  = 4'b0001 << ex_alu_out[1:0];
                st_din_s = {(DWIDTH/8){ex_rs2_data[7:0]}};
            end
            2'b01: begin
                st_we_s  = 4'b0011 << {ex_alu_out[1], 1'b0};
                st_din_s = {(DWIDTH/16){ex_rs2_data[15:0]}};
            end
            default: begin
                st_we_s  = 4'b1111;
                st_din_s = ex_rs2_data;
            end
        endcase
    end

    // Non-memory writeback source select
    always_comb begin
        case (ex_wb_sel)
            WB_PC4:  result_s = ex_pc + DWIDTH'(3'd4);
            WB_CSR:  result_s = ex_csr_data;
            default: result_s = ex_alu_out;
        endcase
    end

    mem_wb_load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .funct3  (funct3_r),
        .addr_lo (addr_lo_r),
        .word    (dmem.dout),
        .data    (load_data_s)
    );

    // Stage FSM with all bus and writeback outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            rd_r           <= 5'd0;
            funct3_r       <= 3'd0;
            addr_lo_r      <= 2'd0;
            is_store_r     <= 1'b0;
            dmem.req_valid <= 1'b0;
            dmem.addr      <= '0;
            dmem.we        <= 4'b0000;
            dmem.din       <= '0;
            wb_we          <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= '0;
            misalign_err   <= 1'b0;
        end else begin
            wb_we        <= 1'b0;
            misalign_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && mem_op_s && misalign_s) begin
                        misalign_err <= 1'b1;
                    end else if (ex_valid && mem_op_s) begin
                        rd_r           <= ex_rd;
                        funct3_r       <= ex_funct3;
                        addr_lo_r      <= ex_alu_out[1:0];
                        is_store_r     <= ex_mem_wr;
                        dmem.req_valid <= 1'b1;
                        dmem.addr      <= ex_alu_out[AWIDTH+1:2];
                        if (ex_mem_wr) begin
                            dmem.we  <= st_we_s;
                            dmem.din <= st_din_s;
                        end else begin
                            dmem.we  <= 4'b0000;
                        end
                        state_r <= ST_REQ;
                    end else if (ex_valid && ex_reg_we && (ex_rd != 5'd0)) begin
                        wb_we   <= 1'b1;
                        wb_rd   <= ex_rd;
                        wb_data <= result_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem.req_ready) begin
                        dmem.req_valid <= 1'b0;
                        dmem.we        <= 4'b0000;
                        state_r        <= is_store_r ? ST_IDLE : ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (dmem.rvalid) begin
                        if (rd_r != 5'd0) begin
                            wb_we   <= 1'b1;
                            wb_rd   <= rd_r;
                            wb_data <= load_data_s;
                        end else begin
                            wb_we <= 1'b0;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: directed stimulus pushes expected memory
// requests, writebacks and misalign pulses; a negedge monitor pops and compares.
module tb_mem_wb;
    import mem_wb_pkg::*;

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_out = 32'd0;
    logic [31:0] ex_rs2_data = 32'd0;
    logic [31:0] ex_csr_data = 32'd0;
    logic [31:0] ex_pc = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_reg_we = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [1:0]  ex_wb_sel = 2'd0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    int tests_run = 0;
    int failed = 0;
    int mis_pending = 0;
    req_t exp_req_q[$];
    wb_t  exp_wb_q[$];

    mem_wb_if #(.DWIDTH(32), .AWIDTH(14)) dmem_bus ();

    mem_wb #(.DWIDTH(32), .AWIDTH(14)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_alu_out   (ex_alu_out),
        .ex_rs2_data  (ex_rs2_data),
        .ex_csr_data  (ex_csr_data),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr),
        .ex_funct3    (ex_funct3),
        .ex_wb_sel    (ex_wb_sel),
        .dmem         (dmem_bus),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(dmem_bus.req_valid), 32'd0);
        check({tag, "_dmem_we"},   32'(dmem_bus.we), 32'd0);
        check({tag, "_dmem_addr"}, 32'(dmem_bus.addr), 32'd0);
        check({tag, "_dmem_din"},  dmem_bus.din, 32'd0);
        check({tag, "_wb_we"},     32'(wb_we), 32'd0);
        check({tag, "_wb_rd"},     32'(wb_rd), 32'd0);
        check({tag, "_wb_data"},   wb_data, 32'd0);
        check({tag, "_misalign"},  32'(misalign_err), 32'd0);
        check({tag, "_ex_ready"},  32'(ex_ready), 32'd1);
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard queues
    always @(negedge clk) begin
        wb_t  w;
        req_t r;
        if (rst_n) begin
            if (wb_we) begin
                if (exp_wb_q.size() == 0) begin
                    check("wb_we_unexpected", 32'(wb_we), 32'd0);
                end else begin
                    w = exp_wb_q.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(w.rd));
                    check("wb_data", wb_data, w.data);
                end
            end
            if (dmem_bus.req_valid && dmem_bus.req_ready) begin
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", 32'(dmem_bus.req_valid), 32'd0);
                end else begin
                    r = exp_req_q.pop_front();
                    check("req_addr", 32'(dmem_bus.addr), 32'(r.addr));
                    check("req_we", 32'(dmem_bus.we), 32'(r.we));
                    if (r.we != 4'b0000) check("req_din", dmem_bus.din, r.din);
                end
            end else if (dmem_bus.req_valid && exp_req_q.size() == 0) begin
                check("req_unexpected", 32'(dmem_bus.req_valid), 32'd0);
            end
            if (misalign_err) begin
                if (mis_pending == 0) check("misalign_unexpected", 32'(misalign_err), 32'd0);
                else mis_pending--;
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic send(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] csr,
                        input logic [31:0] pc, input logic [4:0] rd, input logic reg_we,
                        input logic mem_rd, input logic mem_wr, input logic [2:0] f3, input logic [1:0] sel);
        int n = 0;
        while (!ex_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ex_ready_before_issue", 32'(ex_ready), 32'd1);
        ex_alu_out = alu; ex_rs2_data = rs2; ex_csr_data = csr; ex_pc = pc;
        ex_rd = rd; ex_reg_we = reg_we; ex_mem_rd = mem_rd; ex_mem_wr = mem_wr;
        ex_funct3 = f3; ex_wb_sel = sel; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic reg_we, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr,
                          input logic expect_wb, input logic [31:0] exp_data);
        if (expect_wb) exp_wb_q.push_back('{rd, exp_data});
        send(alu, 32'd0, csr, pc, rd, reg_we, 1'b0, 1'b0, 3'd0, sel);
    endtask

    task automatic hold_req(input int stall, input logic [13:0] ea, input logic [3:0] ew, input logic [31:0] ed);
        for (int i = 0; i < stall; i++) begin
            check("stall_req_valid", 32'(dmem_bus.req_valid), 32'd1);
            check("stall_addr", 32'(dmem_bus.addr), 32'(ea));
            check("stall_we", 32'(dmem_bus.we), 32'(ew));
            if (ew != 4'b0000) check("stall_din", dmem_bus.din, ed);
            check("stall_ex_ready", 32'(ex_ready), 32'd0);
            @(posedge clk); #1;
        end
        dmem_bus.req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_bus.req_ready = 1'b0;
    endtask

    task automatic store_op(input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                            input int stall, input logic [13:0] ea, input logic [3:0] ew, input logic [31:0] ed);
        exp_req_q.push_back('{ea, ew, ed});
        send(addr, rs2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, f3, 2'd0);
        hold_req(stall, ea, ew, ed);
        check("store_ex_ready_after", 32'(ex_ready), 32'd1);
        check("store_req_dropped", 32'(dmem_bus.req_valid), 32'd0);
    endtask

    task automatic load_op(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                           input logic [4:0] rd, input int rv_delay, input logic [31:0] exp_data);
        logic [13:0] wa;
        wa = addr[15:2];
        exp_req_q.push_back('{wa, 4'b0000, 32'd0});
        if (rd != 5'd0) exp_wb_q.push_back('{rd, exp_data});
        send(addr, 32'd0, 32'd0, 32'd0, rd, 1'b1, 1'b1, 1'b0, f3, 2'd1);
        hold_req(0, wa, 4'b0000, 32'd0);
        for (int i = 0; i < rv_delay; i++) begin
            check("load_wait_ex_ready", 32'(ex_ready), 32'd0);
            check("load_wait_no_wb", 32'(wb_we), 32'd0);
            @(posedge clk); #1;
        end
        dmem_bus.rvalid = 1'b1; dmem_bus.dout = word;
        @(posedge clk); #1;
        dmem_bus.rvalid = 1'b0; dmem_bus.dout = 32'h5A5A_5A5A;
        check("load_wb_timing", 32'(wb_we), 32'(rd != 5'd0));
        check("load_ex_ready_after", 32'(ex_ready), 32'd1);
    endtask

    task automatic misaligned_op(input logic [31:0] addr, input logic [2:0] f3, input logic is_store);
        mis_pending++;
        send(addr, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd6, ~is_store, ~is_store, is_store, f3, 2'd1);
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_no_req", 32'(dmem_bus.req_valid), 32'd0);
        check("mis_ex_ready", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        check("mis_no_wb", 32'(wb_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        dmem_bus.req_ready = 1'b0;
        dmem_bus.rvalid    = 1'b0;
        dmem_bus.dout      = 32'd0;
        #3;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // Non-memory ops, back-to-back
        alu_op(5'd5, 1'b1, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b1, 32'h0000_1234);
        alu_op(5'd0, 1'b1, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 32'd0);
        alu_op(5'd7, 1'b1, 2'd2, 32'h1111_1111, 32'h0000_0100, 32'd0, 1'b1, 32'h0000_0104);
        alu_op(5'd8, 1'b1, 2'd3, 32'h2222_2222, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        alu_op(5'd9, 1'b0, 2'd0, 32'h3333_3333, 32'd0, 32'd0, 1'b0, 32'd0);
        check("wb_hold_rd", 32'(wb_rd), 32'd8);
        check("wb_hold_data", wb_data, 32'hDEAD_BEEF);

        // Stores
        store_op(32'h0000_0103, 32'h0000_00AB, FNC_SB, 3, 14'h040, 4'b1000, 32'hABAB_ABAB);
        store_op(32'h0000_0202, 32'h1234_BEEF, FNC_SH, 0, 14'h080, 4'b1100, 32'hBEEF_BEEF);
        store_op(32'h0000_0010, 32'hCAFE_F00D, FNC_SW, 1, 14'h004, 4'b1111, 32'hCAFE_F00D);

        // Loads
        load_op(32'h0000_0002, FNC_LB,  32'h0080_FF00, 5'd10, 0, 32'hFFFF_FF80);
        load_op(32'h0000_0002, FNC_LBU, 32'h0080_FF00, 5'd11, 0, 32'h0000_0080);
        load_op(32'h0000_0001, FNC_LB,  32'h0080_FF00, 5'd15, 0, 32'hFFFF_FFFF);
        load_op(32'h0000_0002, FNC_LH,  32'h8001_0000, 5'd12, 0, 32'hFFFF_8001);
        load_op(32'h0000_0002, FNC_LHU, 32'h8001_0000, 5'd13, 0, 32'h0000_8001);
        load_op(32'h0000_0008, FNC_LW,  32'h1234_5678, 5'd14, 3, 32'h1234_5678);
        load_op(32'h0000_000C, FNC_LW,  32'h7777_7777, 5'd0,  0, 32'd0);

        // Misaligned accesses
        misaligned_op(32'h0000_0006, FNC_LW, 1'b0);
        misaligned_op(32'h0000_0001, FNC_SH, 1'b1);

        // Spurious rvalid while idle
        dmem_bus.rvalid = 1'b1; dmem_bus.dout = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_bus.rvalid = 1'b0;
        @(posedge clk); #1;
        check("spurious_rvalid_no_wb", 32'(wb_we), 32'd0);
        check("spurious_rvalid_hold", wb_data, 32'h1234_5678);

        // Reset while waiting for read data
        exp_req_q.push_back('{14'h001, 4'b0000, 32'd0});
        send(32'h0000_0004, 32'd0, 32'd0, 32'd0, 5'd20, 1'b1, 1'b1, 1'b0, FNC_LW, 2'd1);
        hold_req(0, 14'h001, 4'b0000, 32'd0);
        check("wait_before_reset", 32'(ex_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_wait_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_bus.rvalid = 1'b1; dmem_bus.dout = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        dmem_bus.rvalid = 1'b0;
        check("late_rvalid_no_wb", 32'(wb_we), 32'd0);
        check("late_rvalid_ex_ready", 32'(ex_ready), 32'd1);
        alu_op(5'd3, 1'b1, 2'd0, 32'h0000_0055, 32'd0, 32'd0, 1'b1, 32'h0000_0055);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("wb_queue_drained", 32'(exp_wb_q.size()), 32'd0);
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("misalign_drained", 32'(mis_pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
# mem_wb

Memory/writeback stage of the RISC-V core, directly downstream of EX. It accepts one instruction per handshake from EX, which supplies the ALU result, forwarded rs2, CSR read data and PC. It drives the data-memory request/response port, aligns store data and byte enables, and sign/zero-extends load data. It also produces the registered register-file write port, which doubles as the forwarding source (`forward_data_in`) back into EX.

## Interface
- DWIDTH, 32, datapath width
- AWIDTH, 14, dmem word-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
- ex_alu_out  in  DWIDTH  ALU result / effective byte address
- ex_rs2_data  in  DWIDTH  store data, already forwarded
- ex_csr_data  in  DWIDTH  CSR read value
- ex_pc  in  DWIDTH  instruction PC
- ex_rd  in  5  destination register
- ex_reg_we  in  1  instruction writes rd
- ex_mem_rd / ex_mem_wr  in  1 each  load / store (never both)
- ex_funct3  in  3  load/store width (`FNC_LB..FNC_LHU`, `FNC_SB..FNC_SW`)
- ex_wb_sel  in  2  0=ALU, 1=MEM, 2=PC+4, 3=CSR
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  AWIDTH  word address (byte address [AWIDTH+1:2])
- dmem_we  out  4  byte enables; 0 = read
- dmem_din  out  DWIDTH  store data, lane-aligned
- dmem_rvalid  in  1  read data valid
- dmem_dout  in  DWIDTH  read data word
- wb_we  out  1  regfile write strobe
- wb_rd  out  5  regfile address
- wb_data  out  DWIDTH  regfile write data / forward value
- misalign_err  out  1  one-cycle pulse on misaligned access

## Operation
- FSM: IDLE, REQ, WAIT. ex_ready = (state == IDLE).
- IDLE, accept, non-memory op: latch rd and the selected result (ALU / PC+4 / CSR); next cycle wb_we = ex_reg_we && rd != 0. Stay in IDLE.
- IDLE, accept, load/store aligned: latch address, funct3, rd, and aligned store data/enables; go to REQ.
- Misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0): no request, no writeback. misalign_err pulses the cycle after accept. Stay in IDLE.
- REQ: dmem_req_valid=1, outputs stable until dmem_req_ready. On handshake, a store returns to IDLE and a load goes to WAIT.
- WAIT: on dmem_rvalid, extract the lane and extend (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word). Next cycle wb_we (rd≠0), go to IDLE.
- Store alignment:
  - SB: we=0001<<addr[1:0], byte replicated ×4.
  - SH: we=0011<<{addr[1],0}, halfword replicated ×2.
  - SW: we=1111.
- dmem_rvalid is sampled only in WAIT and ignored in IDLE/REQ.
- wb_we is a one-cycle pulse; wb_rd/wb_data hold their last value between pulses.

## Timing
- Reset: state=IDLE. ex_ready=1 once reset releases. dmem_req_valid=0, dmem_we=0, dmem_addr=0, dmem_din=0, wb_we=0, wb_rd=0, wb_data=0, misalign_err=0.
- Non-memory op: accept at N, wb_we at N+1. Back-to-back sustains one per cycle.
- Store: accept N, req_valid from N+1, completes the cycle ready is seen; ex_ready returns the next cycle.
- Load: accept N, req N+1 (ready at R≥N+1), rvalid at V≥R+1, wb_we at V+1, ex_ready at V+1.
- Minimum load latency, accept to wb_we: 3 cycles.
- Reset asserted mid-REQ/WAIT: immediate return to IDLE and all outputs to reset values. A late rvalid after reset is ignored.

## Structure
- wb_sel encodings and the FSM state encoding go in the shared header alongside Opcode.vh. funct3 codes come from Opcode.vh.
- Sub-module `load_align`: combinational; takes funct3, addr[1:0] and word, and returns the extended value.
- Store lane alignment stays inline.

## Test plan
- ALU op: rd=5, wb_sel=0, alu_out=0x1234 -> wb_we=1, wb_rd=5, wb_data=0x1234 one cycle later. Same op with rd=0 -> wb_we=0.
- SB: addr=0x103, rs2=0xAB -> dmem_addr=0x40, we=1000, din=0xABABABAB. With ready held low 3 cycles, outputs stay stable and ex_ready=0.
- LB/LBU: addr=0x2, dout=0x0080FF00 -> LB wb_data=0xFFFFFF80, LBU wb_data=0x00000080.
- LH: addr=0x2, dout=0x80010000 -> wb_data=0xFFFF8001. LW: addr=0x6 -> misalign_err pulse, no request, no wb_we.
- Load with rvalid arriving 4 cycles after the handshake -> wb_we exactly once, the cycle after rvalid; a spurious rvalid in IDLE is ignored.
- rst_n low during WAIT -> all outputs 0 asynchronously; the rvalid that follows is ignored. After reset release, a new ALU op completes normally.
